// File: rtl/i2c_bridge_pkg.sv
// i2c_bridge_pkg: shared constants for the I2C register bridge.
//   ST_*               3-bit FSM state encodings
//   DEFAULT_ADDR_WIDTH default register pointer width
//   CNT_W              width of the saturating transfer counters
package i2c_bridge_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR_ACK = 3'd1;
  localparam logic [2:0] ST_PTR      = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int CNT_W              = 16;

endpackage

// File: rtl/i2c_bridge_regfile.sv
// i2c_bridge_regfile: byte register file, cleared on reset.
//   clk, i_rst      clock, synchronous active-low reset
//   i_we_mask       per-entry write enable (merged I2C/local port)
//   i_wdata         per-entry write data
//   i_rd_addr_a/b   read addresses
//   o_rd_data_a/b   registered read data, write-first
module i2c_bridge_regfile #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 i_rst,
  input  logic [(1<<ADDR_WIDTH)-1:0]           i_we_mask,
  input  logic [(1<<ADDR_WIDTH)-1:0][7:0]      i_wdata,
  input  logic [ADDR_WIDTH-1:0]                i_rd_addr_a,
  output logic [7:0]                           o_rd_data_a,
  input  logic [ADDR_WIDTH-1:0]                i_rd_addr_b,
  output logic [7:0]                           o_rd_data_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      o_rd_data_a <= '0;
      o_rd_data_b <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (i_we_mask[i]) r_mem[i] <= i_wdata[i];
      // Bypass so a read of an entry being written returns the new byte.
      o_rd_data_a <= i_we_mask[i_rd_addr_a] ? i_wdata[i_rd_addr_a] : r_mem[i_rd_addr_a];
      o_rd_data_b <= i_we_mask[i_rd_addr_b] ? i_wdata[i_rd_addr_b] : r_mem[i_rd_addr_b];
    end
  end

endmodule

// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge: auto-incrementing register bridge behind an I2C slave.
//   clk, rst                     clock, synchronous active-low reset
//   dev_addr_match/ack/nack/
//   start_cond/stop_cond/din     slave byte-level events and received byte
//   send_data                    byte for the slave to shift out on reads
//   loc_we/loc_addr/loc_wdata/
//   loc_rdata                    local fabric register port
//   reg_wr_strobe/addr/data      notification of each I2C register write
//   collision                    local write dropped in favour of I2C write
//   wr_bytes/rd_bytes            saturating transfer counters
//   ptr                          current register pointer
module i2c_reg_bridge
  import i2c_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dev_addr_match,
  input  logic                  ack,
  input  logic                  nack,
  input  logic                  start_cond,
  input  logic                  stop_cond,
  input  logic [7:0]            din,
  output logic [7:0]            send_data,
  input  logic                  loc_we,
  input  logic [ADDR_WIDTH-1:0] loc_addr,
  input  logic [7:0]            loc_wdata,
  output logic [7:0]            loc_rdata,
  output logic                  reg_wr_strobe,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [7:0]            reg_wr_data,
  output logic                  collision,
  output logic [CNT_W-1:0]      wr_bytes,
  output logic [CNT_W-1:0]      rd_bytes,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CNT_W-1:0]      r_wr_bytes;
  logic [CNT_W-1:0]      r_rd_bytes;
  logic                  r_wr_strobe;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_collision;

  logic                  w_bus_ctrl;
  logic                  w_byte_ev;
  logic                  w_i2c_we;
  logic                  w_rd_step;
  logic [DEPTH-1:0]      w_we_mask;
  logic [DEPTH-1:0][7:0] w_wdata;

  assign w_bus_ctrl = start_cond | stop_cond;
  // ack/nack only act when no higher-priority event is present this cycle.
  assign w_byte_ev  = ~w_bus_ctrl & ~dev_addr_match;
  assign w_i2c_we   = w_byte_ev & ack & (r_state == ST_WRITE);
  assign w_rd_step  = w_byte_ev & (ack | nack) & (r_state == ST_READ);

  // I2C write is applied last so it overrides a local write to the same entry.
  always_comb begin
    w_we_mask = '0;
    w_wdata   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (loc_we && loc_addr == ADDR_WIDTH'(i)) begin
        w_we_mask[i] = 1'b1;
        w_wdata[i]   = loc_wdata;
      end
      if (w_i2c_we && r_ptr == ADDR_WIDTH'(i)) begin
        w_we_mask[i] = 1'b1;
        w_wdata[i]   = din;
      end
    end
  end

  i2c_bridge_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk         (clk),
    .i_rst       (rst),
    .i_we_mask   (w_we_mask),
    .i_wdata     (w_wdata),
    .i_rd_addr_a (r_ptr),
    .o_rd_data_a (send_data),
    .i_rd_addr_b (loc_addr),
    .o_rd_data_b (loc_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_wr_bytes  <= '0;
      r_rd_bytes  <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_collision <= 1'b0;
    end else begin
      r_wr_strobe <= w_i2c_we;
      r_collision <= w_i2c_we & loc_we & (loc_addr == r_ptr);
      if (w_i2c_we) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= din;
      end
      if (w_i2c_we && r_wr_bytes != '1) r_wr_bytes <= r_wr_bytes + CNT_W'(1);
      if (w_rd_step && r_rd_bytes != '1) r_rd_bytes <= r_rd_bytes + CNT_W'(1);

      if (w_bus_ctrl) begin
        r_state <= ST_IDLE;
      end else if (dev_addr_match) begin
        r_state <= ST_ADDR_ACK;
      end else begin
        case (r_state)
          ST_ADDR_ACK: begin
            if (ack)       r_state <= din[0] ? ST_READ : ST_PTR;
            else if (nack) r_state <= ST_IDLE;
          end
          ST_PTR: begin
            if (ack) begin
              r_ptr   <= din[ADDR_WIDTH-1:0];
              r_state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (ack) r_ptr <= r_ptr + ADDR_WIDTH'(1);
          end
          ST_READ: begin
            if (ack) begin
              r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end else if (nack) begin
              r_ptr   <= r_ptr + ADDR_WIDTH'(1);
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign reg_wr_strobe = r_wr_strobe;
  assign reg_wr_addr   = r_wr_addr;
  assign reg_wr_data   = r_wr_data;
  assign collision     = r_collision;
  assign wr_bytes      = r_wr_bytes;
  assign rd_bytes      = r_rd_bytes;
  assign ptr           = r_ptr;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb_i2c_reg_bridge: directed self-checking bench for i2c_reg_bridge.
module tb_i2c_reg_bridge;

  logic        clk;
  logic        rst;
  logic        dev_addr_match, ack, nack, start_cond, stop_cond;
  logic [7:0]  din;
  logic [7:0]  send_data;
  logic        loc_we;
  logic [3:0]  loc_addr;
  logic [7:0]  loc_wdata;
  logic [7:0]  loc_rdata;
  logic        reg_wr_strobe;
  logic [3:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        collision;
  logic [15:0] wr_bytes, rd_bytes;
  logic [3:0]  ptr;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;
  int coll_cnt    = 0;

  i2c_reg_bridge #(
    .ADDR_WIDTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dev_addr_match (dev_addr_match),
    .ack            (ack),
    .nack           (nack),
    .start_cond     (start_cond),
    .stop_cond      (stop_cond),
    .din            (din),
    .send_data      (send_data),
    .loc_we         (loc_we),
    .loc_addr       (loc_addr),
    .loc_wdata      (loc_wdata),
    .loc_rdata      (loc_rdata),
    .reg_wr_strobe  (reg_wr_strobe),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .collision      (collision),
    .wr_bytes       (wr_bytes),
    .rd_bytes       (rd_bytes),
    .ptr            (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr_strobe === 1'b1) strobe_cnt++;
    if (collision === 1'b1) coll_cnt++;
  end

  // Called at a falling edge: holds the event for exactly one rising edge.
  task automatic drive(input logic s, input logic p, input logic m,
                       input logic a, input logic n, input logic [7:0] d);
    start_cond = s; stop_cond = p; dev_addr_match = m; ack = a; nack = n; din = d;
    @(negedge clk);
    start_cond = 0; stop_cond = 0; dev_addr_match = 0; ack = 0; nack = 0; din = '0;
    loc_we = 0;
  endtask

  task automatic do_start();           drive(1, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_stop();            drive(0, 1, 0, 0, 0, 8'h00); endtask
  task automatic do_match();           drive(0, 0, 1, 0, 0, 8'h00); endtask
  task automatic do_ack(input logic [7:0] d); drive(0, 0, 0, 1, 0, d); endtask
  task automatic do_nack();            drive(0, 0, 0, 0, 1, 8'h00); endtask
  task automatic idle(input int n);    repeat (n) @(negedge clk); endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
    loc_addr = a;
    @(negedge clk);
    v = loc_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0;
    idle(2);
    vectors++; if (send_data !== 8'h00) begin miscompares++; $display("FAIL reset_send_data: got %h expected 00", send_data); end
    vectors++; if (ptr !== 4'h0) begin miscompares++; $display("FAIL reset_ptr: got %h expected 0", ptr); end
    vectors++; if (wr_bytes !== 16'h0 || rd_bytes !== 16'h0) begin miscompares++; $display("FAIL reset_counters: got wr=%h rd=%h expected 0/0", wr_bytes, rd_bytes); end
    vectors++; if (reg_wr_strobe !== 1'b0 || collision !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got strobe=%b coll=%b expected 0/0", reg_wr_strobe, collision); end
    vectors++; if (reg_wr_addr !== 4'h0 || reg_wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_info: got addr=%h data=%h expected 0/00", reg_wr_addr, reg_wr_data); end
    rst = 1'b1;
    read_reg(4'h5, v);
    vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL reset_reg5: got %h expected 00", v); end
  endtask

  task automatic test_write();
    logic [7:0] v;
    strobe_cnt = 0;
    do_start(); do_match(); do_ack(8'h20); do_ack(8'h05);
    do_ack(8'hA1);
    vectors++; if (reg_wr_strobe !== 1'b1 || reg_wr_addr !== 4'h5 || reg_wr_data !== 8'hA1) begin
      miscompares++; $display("FAIL write_strobe: got %b/%h/%h expected 1/5/a1", reg_wr_strobe, reg_wr_addr, reg_wr_data); end
    do_ack(8'hB2); do_stop(); idle(2);
    vectors++; if (strobe_cnt !== 2) begin miscompares++; $display("FAIL write_strobe_cnt: got %0d expected 2", strobe_cnt); end
    vectors++; if (wr_bytes !== 16'd2) begin miscompares++; $display("FAIL write_wr_bytes: got %0d expected 2", wr_bytes); end
    vectors++; if (ptr !== 4'h7) begin miscompares++; $display("FAIL write_ptr: got %h expected 7", ptr); end
    read_reg(4'h5, v);
    vectors++; if (v !== 8'hA1) begin miscompares++; $display("FAIL write_reg5: got %h expected a1", v); end
    read_reg(4'h6, v);
    vectors++; if (v !== 8'hB2) begin miscompares++; $display("FAIL write_reg6: got %h expected b2", v); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    strobe_cnt = 0;
    // 0xFF pointer byte: upper bits are ignored, giving 0xF.
    do_start(); do_match(); do_ack(8'h20); do_ack(8'hFF);
    do_ack(8'h11); do_ack(8'h22); do_stop(); idle(2);
    vectors++; if (ptr !== 4'h1) begin miscompares++; $display("FAIL wrap_ptr: got %h expected 1", ptr); end
    vectors++; if (wr_bytes !== 16'd4) begin miscompares++; $display("FAIL wrap_wr_bytes: got %0d expected 4", wr_bytes); end
    vectors++; if (strobe_cnt !== 2) begin miscompares++; $display("FAIL wrap_strobe_cnt: got %0d expected 2", strobe_cnt); end
    read_reg(4'hF, v);
    vectors++; if (v !== 8'h11) begin miscompares++; $display("FAIL wrap_reg15: got %h expected 11", v); end
    read_reg(4'h0, v);
    vectors++; if (v !== 8'h22) begin miscompares++; $display("FAIL wrap_reg0: got %h expected 22", v); end
  endtask

  task automatic test_read();
    // Preload reg[3]=0x33, reg[4]=0x44; reg[5] still 0xA1.
    do_start(); do_match(); do_ack(8'h20); do_ack(8'h03); do_ack(8'h33); do_ack(8'h44); do_stop();
    // Pointer write, repeated start, read three bytes.
    do_start(); do_match(); do_ack(8'h20); do_ack(8'h03);
    do_start(); do_match(); do_ack(8'h21); idle(1);
    vectors++; if (send_data !== 8'h33) begin miscompares++; $display("FAIL read_byte0: got %h expected 33", send_data); end
    do_ack(8'h00); idle(1);
    vectors++; if (send_data !== 8'h44) begin miscompares++; $display("FAIL read_byte1: got %h expected 44", send_data); end
    do_ack(8'h00); idle(1);
    vectors++; if (send_data !== 8'hA1) begin miscompares++; $display("FAIL read_byte2: got %h expected a1", send_data); end
    do_nack(); idle(2);
    vectors++; if (rd_bytes !== 16'd3) begin miscompares++; $display("FAIL read_rd_bytes: got %0d expected 3", rd_bytes); end
    vectors++; if (ptr !== 4'h6) begin miscompares++; $display("FAIL read_ptr: got %h expected 6", ptr); end
    vectors++; if (wr_bytes !== 16'd6) begin miscompares++; $display("FAIL read_wr_bytes: got %0d expected 6", wr_bytes); end
    vectors++; if (send_data !== 8'hB2) begin miscompares++; $display("FAIL read_send_after: got %h expected b2", send_data); end
    // Back in IDLE: a stray ack must not move anything.
    do_ack(8'h00); idle(1);
    vectors++; if (ptr !== 4'h6 || rd_bytes !== 16'd3) begin
      miscompares++; $display("FAIL read_idle_ack: got ptr=%h rd=%0d expected 6/3", ptr, rd_bytes); end
    do_stop();
  endtask

  task automatic test_collision();
    logic [7:0] v;
    coll_cnt = 0;
    do_start(); do_match(); do_ack(8'h20); do_ack(8'h02);
    loc_we = 1'b1; loc_addr = 4'h2; loc_wdata = 8'h55;
    do_ack(8'h99);
    vectors++; if (collision !== 1'b1 || reg_wr_data !== 8'h99) begin
      miscompares++; $display("FAIL coll_pulse: got coll=%b data=%h expected 1/99", collision, reg_wr_data); end
    loc_we = 1'b1; loc_addr = 4'h8; loc_wdata = 8'h5A;
    do_ack(8'h77);
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL coll_parallel_pulse: got %b expected 0", collision); end
    do_stop(); idle(2);
    vectors++; if (coll_cnt !== 1) begin miscompares++; $display("FAIL coll_cnt: got %0d expected 1", coll_cnt); end
    vectors++; if (wr_bytes !== 16'd8 || ptr !== 4'h4) begin
      miscompares++; $display("FAIL coll_state: got wr=%0d ptr=%h expected 8/4", wr_bytes, ptr); end
    read_reg(4'h2, v);
    vectors++; if (v !== 8'h99) begin miscompares++; $display("FAIL coll_reg2: got %h expected 99", v); end
    read_reg(4'h3, v);
    vectors++; if (v !== 8'h77) begin miscompares++; $display("FAIL coll_reg3: got %h expected 77", v); end
    read_reg(4'h8, v);
    vectors++; if (v !== 8'h5A) begin miscompares++; $display("FAIL coll_reg8: got %h expected 5a", v); end
    // Local write and read of the same entry in one cycle: write-first.
    loc_we = 1'b1; loc_addr = 4'hA; loc_wdata = 8'hC3;
    @(negedge clk);
    loc_we = 1'b0;
    vectors++; if (loc_rdata !== 8'hC3) begin miscompares++; $display("FAIL loc_write_first: got %h expected c3", loc_rdata); end
  endtask

  task automatic test_mismatch();
    logic [7:0] v;
    strobe_cnt = 0;
    do_start(); do_ack(8'h44); do_nack(); do_ack(8'h12); do_stop(); idle(2);
    vectors++; if (ptr !== 4'h4) begin miscompares++; $display("FAIL mism_ptr: got %h expected 4", ptr); end
    vectors++; if (wr_bytes !== 16'd8 || rd_bytes !== 16'd3) begin
      miscompares++; $display("FAIL mism_counters: got wr=%0d rd=%0d expected 8/3", wr_bytes, rd_bytes); end
    vectors++; if (strobe_cnt !== 0) begin miscompares++; $display("FAIL mism_strobe: got %0d expected 0", strobe_cnt); end
    read_reg(4'h4, v);
    vectors++; if (v !== 8'h44) begin miscompares++; $display("FAIL mism_reg4: got %h expected 44", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_start(); do_match(); do_ack(8'h20); do_ack(8'h09);
    vectors++; if (ptr !== 4'h9) begin miscompares++; $display("FAIL rstmid_ptr_pre: got %h expected 9", ptr); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    strobe_cnt = 0;
    do_ack(8'h66); idle(2);
    vectors++; if (ptr !== 4'h0) begin miscompares++; $display("FAIL rstmid_ptr: got %h expected 0", ptr); end
    vectors++; if (strobe_cnt !== 0) begin miscompares++; $display("FAIL rstmid_strobe: got %0d expected 0", strobe_cnt); end
    vectors++; if (wr_bytes !== 16'd0 || rd_bytes !== 16'd0) begin
      miscompares++; $display("FAIL rstmid_counters: got wr=%0d rd=%0d expected 0/0", wr_bytes, rd_bytes); end
    vectors++; if (send_data !== 8'h00) begin miscompares++; $display("FAIL rstmid_send_data: got %h expected 00", send_data); end
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL rstmid_reg%0d: got %h expected 00", i, v); end
    end
  endtask

  initial begin
    rst = 1'b0;
    dev_addr_match = 0; ack = 0; nack = 0; start_cond = 0; stop_cond = 0; din = '0;
    loc_we = 0; loc_addr = '0; loc_wdata = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_wrap();
    test_read();
    test_collision();
    test_mismatch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bridge.md
# i2c_reg_bridge

Byte-register bridge sitting directly downstream of the FPGA's I2C slave engine. It consumes the slave's per-byte event pulses (address match, ACK/NACK, received byte) and implements an auto-incrementing register pointer over a small register file. It supplies the slave's `send_data` for master reads and exposes a local fabric port plus transfer statistics to the rest of the test shield.

## Interface
- `ADDR_WIDTH`, default 4: register file holds 2^ADDR_WIDTH bytes; pointer width.
- `clk  in  1`: system clock, same domain as the I2C slave.
- `rst  in  1`: reset, synchronous, active-low; clock `clk`.
- `dev_addr_match  in  1`: slave pulse; the address byte matched.
- `ack  in  1`: slave pulse; a byte was ACKed, by the slave on writes or by the master on reads.
- `nack  in  1`: slave pulse; a byte was NACKed.
- `start_cond  in  1`: slave start or repeated-start pulse.
- `stop_cond  in  1`: slave stop pulse.
- `din  in  8`: last byte received by the slave; valid whenever `ack` is high.
- `send_data  out  8`: byte the slave shifts out on reads; registered.
- `loc_we  in  1`: local register write enable.
- `loc_addr  in  ADDR_WIDTH`: local read/write address.
- `loc_wdata  in  8`: local write data.
- `loc_rdata  out  8`: registered read of `reg[loc_addr]`.
- `reg_wr_strobe  out  1`: one-cycle pulse after each I2C register write.
- `reg_wr_addr  out  ADDR_WIDTH`: address of that write.
- `reg_wr_data  out  8`: data of that write.
- `collision  out  1`: one-cycle pulse when a local write was dropped.
- `wr_bytes  out  16`: saturating count of I2C data bytes written.
- `rd_bytes  out  16`: saturating count of I2C bytes read.
- `ptr  out  ADDR_WIDTH`: current register pointer.

## Operation
- States:
  - `IDLE`: no transaction in progress.
  - `ADDR_ACK`: address matched; waiting for the address-phase ACK/NACK.
  - `PTR`: next write byte is the pointer.
  - `WRITE`: bytes are register writes.
  - `READ`: master is reading.
- Event priority, highest first: reset > `start_cond` / `stop_cond` > `dev_addr_match` > `ack` / `nack`.
- From any state:
  - `start_cond` or `stop_cond` goes to `IDLE`.
  - `dev_addr_match` goes to `ADDR_ACK`.
- `ADDR_ACK`:
  - On `ack` with `din[0]=1`, go to `READ`.
  - On `ack` with `din[0]=0`, go to `PTR`.
  - On `nack`, go to `IDLE`.
- `PTR`:
  - On `ack`, `ptr <= din[ADDR_WIDTH-1:0]` (upper bits ignored), then go to `WRITE`.
  - `wr_bytes` does not count the pointer byte.
- `WRITE`:
  - On `ack`, `reg[ptr] <= din`, `ptr <= ptr+1`, `wr_bytes++`, pulse `reg_wr_strobe`.
- `READ`:
  - On `ack`, `ptr++` and `rd_bytes++`.
  - On `nack`, do the same, then go to `IDLE`.
- `ack` / `nack` in `IDLE` are ignored.
- Pointer arithmetic is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.
- The pointer is retained across stop and repeated start. This allows a write-pointer, repeated-start, read sequence.
- `send_data <= reg[ptr]` every cycle. It therefore reflects pointer and data changes with one cycle of latency.
- Local write collision:
  - Condition: `loc_we` targets the same address as an I2C write in the same cycle.
  - The I2C write wins, the local write is dropped, and `collision` pulses.
  - Local writes to different addresses proceed in parallel.
- Counters saturate at 0xFFFF.
- Reset values: all outputs 0, `state = IDLE`, `ptr = 0`, every register byte 0.

## Timing
- All slave inputs are sampled at `clk` edge N.
- Register file and `ptr` update at edge N.
- `reg_wr_strobe`, `reg_wr_addr`, `reg_wr_data`, `collision` and the counters are valid in cycle N+1.
- `send_data` reflects the new pointer at N+1. This is far ahead of the next SCL falling edge, so the slave always loads a stable byte.
- `loc_rdata`: 1-cycle latency from `loc_addr`. It shows same-cycle writes on the following cycle (write-first).
- Reset mid-transaction: next edge returns to `IDLE` and clears everything. Subsequent `ack` pulses are ignored until a new `dev_addr_match`.

## Structure
- Package `i2c_bridge_pkg` holds:
  - state encoding constants (3 bits);
  - `DEFAULT_ADDR_WIDTH`;
  - counter width (16).
- Sub-module `i2c_bridge_regfile` is a flop array cleared on reset. It has:
  - one merged write port, with I2C priority resolved in the parent;
  - two registered read ports, for `send_data` and `loc_rdata`.
- The FSM, pointer and counters live in the parent.

## Test plan
- Write a 0x05 pointer, then 0xA1 and 0xB2, then stop:
  - `reg[5]=0xA1`, `reg[6]=0xB2`;
  - two `reg_wr_strobe` pulses;
  - `wr_bytes=2`, `ptr=7`.
- Pointer 0x0F, then 0x11 and 0x22:
  - `reg[15]=0x11`, `reg[0]=0x22`;
  - `ptr=1` (wrap).
- Pointer 0x03 write, repeated start, read 3 bytes with master ACK, ACK, NACK:
  - `send_data` is loaded in order with `reg[3]`, `reg[4]`, `reg[5]`;
  - `rd_bytes=3`, `ptr=6`, state `IDLE`.
- Local write `reg[2]=0x55` in the same cycle as an I2C write of 0x99 to pointer 2:
  - `reg[2]=0x99`;
  - `collision` pulses once.
- `dev_addr_mismatch` transaction with stray `nack`: no register, pointer or counter change.
- Reset asserted after the pointer byte, then a data `ack` without `dev_addr_match`:
  - `ptr=0`, all regs 0;
  - no strobe.
